// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one downstream memory port between the fetch (i)
// and load/store (d) requesters, with one-entry request buffers and a hang timeout.
module memory_arbiter #(
  parameter int TIMEOUT = 1023
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        imemory_valid,
  input  logic        imemory_instr,
  input  logic [31:0] imemory_addr,
  input  logic [31:0] imemory_wdata,
  input  logic [3:0]  imemory_wstrb,
  output logic [31:0] imemory_rdata,
  output logic        imemory_error,
  output logic        imemory_ready,
  input  logic        dmemory_valid,
  input  logic        dmemory_instr,
  input  logic [31:0] dmemory_addr,
  input  logic [31:0] dmemory_wdata,
  input  logic [3:0]  dmemory_wstrb,
  output logic [31:0] dmemory_rdata,
  output logic        dmemory_error,
  output logic        dmemory_ready,
  output logic        memory_valid,
  output logic        memory_instr,
  output logic [31:0] memory_addr,
  output logic [31:0] memory_wdata,
  output logic [3:0]  memory_wstrb,
  input  logic [31:0] memory_rdata,
  input  logic        memory_error,
  input  logic        memory_ready,
  output logic [0:0]  debug_state
);

  // Handshake: requester *_valid and memory_valid are single-cycle pulses; a
  // response is qualified only by the one-cycle *_ready pulse, data holds otherwise.

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]    state;
  logic          grant_d;
  logic [CW-1:0] cnt;

  logic          pi_valid, pi_instr;
  logic [31:0]   pi_addr, pi_wdata;
  logic [3:0]    pi_wstrb;
  logic          pd_valid, pd_instr;
  logic [31:0]   pd_addr, pd_wdata;
  logic [3:0]    pd_wstrb;

  logic          done, inflight_i, inflight_d, cap_i, cap_d;
  logic          avail_i, avail_d, grant_any, pick_d;
  logic          sel_instr;
  logic [31:0]   sel_addr, sel_wdata;
  logic [3:0]    sel_wstrb;

  assign debug_state = state;

  // The granted port is released in its completion cycle, so a new request
  // arriving then is captured rather than dropped.
  assign done       = (state == BUSY) && (memory_ready || (cnt == CNT_LAST));
  assign inflight_i = (state == BUSY) && !grant_d && !done;
  assign inflight_d = (state == BUSY) &&  grant_d && !done;
  assign cap_i      = imemory_valid && !pi_valid && !inflight_i;
  assign cap_d      = dmemory_valid && !pd_valid && !inflight_d;
  assign avail_i    = (state == IDLE) && (pi_valid || imemory_valid);
  assign avail_d    = (state == IDLE) && (pd_valid || dmemory_valid);
  assign grant_any  = avail_i || avail_d;
  // grant_d doubles as "last granted": on a tie the other port wins.
  assign pick_d     = avail_d && (!avail_i || !grant_d);

  always_comb begin
    sel_instr = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    if (pick_d) begin
      if (pd_valid) begin
        sel_instr = pd_instr; sel_addr = pd_addr; sel_wdata = pd_wdata; sel_wstrb = pd_wstrb;
      end else begin
        sel_instr = dmemory_instr; sel_addr = dmemory_addr;
        sel_wdata = dmemory_wdata; sel_wstrb = dmemory_wstrb;
      end
    end else if (pi_valid) begin
      sel_instr = pi_instr; sel_addr = pi_addr; sel_wdata = pi_wdata; sel_wstrb = pi_wstrb;
    end else begin
      sel_instr = imemory_instr; sel_addr = imemory_addr;
      sel_wdata = imemory_wdata; sel_wstrb = imemory_wstrb;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      grant_d       <= 1'b0;
      cnt           <= '0;
      pi_valid      <= 1'b0; pi_instr <= 1'b0; pi_addr <= '0; pi_wdata <= '0; pi_wstrb <= '0;
      pd_valid      <= 1'b0; pd_instr <= 1'b0; pd_addr <= '0; pd_wdata <= '0; pd_wstrb <= '0;
      imemory_rdata <= '0; imemory_error <= 1'b0; imemory_ready <= 1'b0;
      dmemory_rdata <= '0; dmemory_error <= 1'b0; dmemory_ready <= 1'b0;
      memory_valid  <= 1'b0; memory_instr <= 1'b0;
      memory_addr   <= '0; memory_wdata <= '0; memory_wstrb <= '0;
    end else begin
      imemory_ready <= 1'b0;
      dmemory_ready <= 1'b0;
      memory_valid  <= 1'b0;

      if (grant_any && !pick_d) begin
        pi_valid <= 1'b0;
      end else if (cap_i) begin
        pi_valid <= 1'b1; pi_instr <= imemory_instr; pi_addr <= imemory_addr;
        pi_wdata <= imemory_wdata; pi_wstrb <= imemory_wstrb;
      end

      if (grant_any && pick_d) begin
        pd_valid <= 1'b0;
      end else if (cap_d) begin
        pd_valid <= 1'b1; pd_instr <= dmemory_instr; pd_addr <= dmemory_addr;
        pd_wdata <= dmemory_wdata; pd_wstrb <= dmemory_wstrb;
      end

      case (state)
        IDLE: begin
          if (grant_any) begin
            memory_valid <= 1'b1;
            memory_instr <= sel_instr;
            memory_addr  <= sel_addr;
            memory_wdata <= sel_wdata;
            memory_wstrb <= sel_wstrb;
            cnt          <= '0;
            grant_d      <= pick_d;
            state        <= BUSY;
          end
        end
        BUSY: begin
          // A real response beats a timeout landing in the same cycle.
          if (memory_ready) begin
            if (grant_d) begin
              dmemory_rdata <= memory_rdata; dmemory_error <= memory_error; dmemory_ready <= 1'b1;
            end else begin
              imemory_rdata <= memory_rdata; imemory_error <= memory_error; imemory_ready <= 1'b1;
            end
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            if (grant_d) begin
              dmemory_rdata <= '0; dmemory_error <= 1'b1; dmemory_ready <= 1'b1;
            end else begin
              imemory_rdata <= '0; imemory_error <= 1'b1; imemory_ready <= 1'b1;
            end
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
